// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush controller.
// Package only: no logic, no latency, no flow control.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/pipe_loaduse_det.sv
// Load-use hazard comparator between the EX-stage load and the ID-stage sources.
// Purely combinational, zero latency, no flow control.
module pipe_loaduse_det (
  input  logic       i_mem_rd,
  input  logic [4:0] i_wn_ex,
  input  logic [4:0] i_rs_id,
  input  logic [4:0] i_rt_id,
  input  logic       i_use_rt,
  output logic       o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_wn_ex == i_rs_id);
  assign w_rt_hit = i_use_rt & (i_wn_ex == i_rt_id);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign o_hazard = i_mem_rd & (i_wn_ex != 5'd0) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: freeze on memory wait > branch flush > load-use stall; zero-latency controls.
// Optional macro PIPE_STALL_TIMEOUT_EN adds a MEM_WAIT timeout with a sticky MemErr flag.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       MEM_EX,
  input  logic [4:0]       WN_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UseRt_ID,
  input  logic [1:0]       MEM_MEM,
  input  logic             MemReady,
  input  logic             BranchTaken_EX,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             MemReq,
  output logic [CNT_W-1:0] StallCnt,
  output logic             MemErr
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_access;
  logic w_wait_req;
  logic w_timeout;
  logic w_freeze;
  logic w_hazard;
  logic w_branch;
  logic w_lu_stall;
  logic w_unused_mem_wr;

  assign w_unused_mem_wr = MEM_EX[MEM_WR];
  assign w_access        = MEM_MEM[MEM_RD] | MEM_MEM[MEM_WR];

  pipe_loaduse_det u_loaduse_det (
    .i_mem_rd (MEM_EX[MEM_RD]),
    .i_wn_ex  (WN_EX),
    .i_rs_id  (Rs_ID),
    .i_rt_id  (Rt_ID),
    .i_use_rt (UseRt_ID),
    .o_hazard (w_hazard)
  );

  assign w_wait_req = (r_state == RUN) ? (w_access & ~MemReady) : ~MemReady;

`ifdef PIPE_STALL_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  assign w_timeout = (r_state == MEM_WAIT) & ~MemReady &
                     ((r_wait_cnt + 8'd1) == 8'(TIMEOUT_CYC));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == RUN) ? 8'd0 : r_wait_cnt + 8'd1;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  assign MemErr = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign MemErr    = 1'b0;
`endif

  // Gating with Rst makes every output take its reset value asynchronously
  assign w_freeze   = Rst & w_wait_req & ~w_timeout;
  assign w_branch   = Rst & ~w_freeze & BranchTaken_EX;
  assign w_lu_stall = Rst & ~w_freeze & ~BranchTaken_EX & w_hazard;

  assign PCWrite      = ~w_freeze & ~w_lu_stall;
  assign IFID_Write   = ~w_freeze & ~w_lu_stall;
  assign IFID_Flush   = w_branch;
  assign IDEX_Write   = ~w_freeze;
  assign IDEX_Flush   = w_branch | w_lu_stall;
  assign EXMEM_Write  = ~w_freeze;
  assign MEMWB_Bubble = w_freeze | (Rst & w_timeout);
  assign MemReq       = Rst & w_access;
  assign StallCnt     = r_stall_cnt;

  // Freeze in RUN enters MEM_WAIT; absence of freeze in MEM_WAIT leaves it
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_freeze ? MEM_WAIT : RUN;
      if ((w_freeze | w_lu_stall) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expected control vectors queued at drive time, compared mid-cycle.
// Timeout scenario is exercised only when PIPE_STALL_TIMEOUT_EN is defined.
module tb_pipe_stall_ctrl;

  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 4;

  // Control vector bit order: PCWrite IFID_Write IFID_Flush IDEX_Write IDEX_Flush EXMEM_Write MEMWB_Bubble MemReq
  localparam logic [7:0] C_NORM    = 8'hD4;
  localparam logic [7:0] C_NORMREQ = 8'hD5;
  localparam logic [7:0] C_LU      = 8'h1C;
  localparam logic [7:0] C_BR      = 8'hFC;
  localparam logic [7:0] C_FRZ     = 8'h03;
  localparam logic [7:0] C_BRREQ   = 8'hFD;
  localparam logic [7:0] C_TMO     = 8'hD7;
  localparam logic [7:0] C_FRZNREQ = 8'h02;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [1:0]       MEM_EX;
  logic [4:0]       WN_EX, Rs_ID, Rt_ID;
  logic             UseRt_ID;
  logic [1:0]       MEM_MEM;
  logic             MemReady;
  logic             BranchTaken_EX;
  logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush;
  logic             EXMEM_Write, MEMWB_Bubble, MemReq, MemErr;
  logic [CNT_W-1:0] StallCnt;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_err = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .MEM_EX         (MEM_EX),
    .WN_EX          (WN_EX),
    .Rs_ID          (Rs_ID),
    .Rt_ID          (Rt_ID),
    .UseRt_ID       (UseRt_ID),
    .MEM_MEM        (MEM_MEM),
    .MemReady       (MemReady),
    .BranchTaken_EX (BranchTaken_EX),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Write     (IDEX_Write),
    .IDEX_Flush     (IDEX_Flush),
    .EXMEM_Write    (EXMEM_Write),
    .MEMWB_Bubble   (MEMWB_Bubble),
    .MemReq         (MemReq),
    .StallCnt       (StallCnt),
    .MemErr         (MemErr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] ctrl);
    exp_t e;
    e.ctrl = ctrl;
    e.cnt  = exp_cnt;
    e.err  = exp_err;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ctrl"}, {24'd0, PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
                             IDEX_Flush, EXMEM_Write, MEMWB_Bubble, MemReq}, {24'd0, e.ctrl});
      check({tag, "_cnt"}, 32'(StallCnt), 32'(e.cnt));
      check({tag, "_err"}, {31'd0, MemErr}, {31'd0, e.err});
    end
  endtask

  // Called just after a rising edge; drives one cycle of stimulus and checks it at the falling edge
  task automatic step(input string tag, input logic [1:0] mex, input logic [4:0] wn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [1:0] mmem, input logic rdy, input logic br,
                      input logic [7:0] ectrl, input logic inc);
    MEM_EX = mex; WN_EX = wn; Rs_ID = rs; Rt_ID = rt; UseRt_ID = urt;
    MEM_MEM = mmem; MemReady = rdy; BranchTaken_EX = br;
    push_exp(ectrl);
    if (inc && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(negedge Clk);
    compare_out(tag);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    MEM_EX = 2'b00; WN_EX = '0; Rs_ID = '0; Rt_ID = '0; UseRt_ID = 1'b0;
    MEM_MEM = 2'b00; MemReady = 1'b0; BranchTaken_EX = 1'b0;
    #2;
    push_exp(C_NORM);
    compare_out("reset");
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    step("idle",      2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_rs",     2'b10, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_LU,   1'b1);
    step("lu_after",  2'b00, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_r0",     2'b10, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_wr",     2'b01, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_rt",     2'b10, 5'd7, 5'd1, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, C_LU,   1'b1);
    step("lu_rt_off", 2'b10, 5'd7, 5'd1, 5'd7, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);

    for (int i = 0; i < 3; i++)
      step("mem_wait", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ, 1'b1);
    step("mem_rel",   2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b0, C_NORMREQ, 1'b0);
    step("mem_1cyc",  2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b1, 1'b0, C_NORMREQ, 1'b0);
    step("br_lu",     2'b10, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, C_BR,   1'b0);

    for (int i = 0; i < 2; i++)
      step("br_frz",  2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1, C_FRZ,  1'b1);
    step("br_rel",    2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b1, C_BRREQ, 1'b0);

    for (int i = 0; i < 2; i++)
      step("pre_rst", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    Rst = 1'b0;
    #1;
    exp_cnt = '0;
    push_exp(C_NORM);
    compare_out("rst_wait");
    MEM_MEM = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    // Would read C_FRZNREQ if the FSM had stayed in MEM_WAIT through reset
    step("post_rst",  2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);

    for (int i = 0; i < 17; i++)
      step("sat",     2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    step("sat_rel",   2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b0, C_NORMREQ, 1'b0);
    step("sat_hold",  2'b10, 5'd3, 5'd3, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_LU,   1'b1);
    step("sat_end",   2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);

`ifdef PIPE_STALL_TIMEOUT_EN
    step("to_entry",  2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++)
      step("to_wait", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    step("to_fire",   2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_TMO,  1'b0);
    exp_err = 1'b1;
    step("to_refrz",  2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    step("to_rel",    2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b0, C_NORMREQ, 1'b0);
    step("to_sticky", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_NORM, 1'b0);
`else
    step("no_to",     2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ,  1'b1);
    for (int i = 0; i < TIMEOUT_CYC + 2; i++)
      step("no_to_hold", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, C_FRZ, 1'b1);
    step("no_to_rel", 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b0, C_NORMREQ, 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers, and the bubble injected into MEM/WB.
- Detects load-use hazards and taken-branch flushes.
- Runs a small FSM that freezes the pipeline while a data-memory access in MEM waits on MemReady. Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- CNT_W, 16, width of the StallCnt performance counter.
- TIMEOUT_CYC, 255, maximum MEM_WAIT cycles before forced release (used only with the optional feature).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- MEM_EX  in  2  EX-stage memory control: bit1 = MemRead, bit0 = MemWrite.
- WN_EX  in  5  EX-stage destination register.
- Rs_ID  in  5  ID-stage source register rs.
- Rt_ID  in  5  ID-stage source register rt.
- UseRt_ID  in  1  ID instruction reads rt.
- MEM_MEM  in  2  MEM-stage memory control, same encoding as MEM_EX.
- MemReady  in  1  data memory completes the current access this cycle.
- BranchTaken_EX  in  1  branch resolved taken in EX.
- PCWrite  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  clear IF/ID to NOP.
- IDEX_Write  out  1  ID/EX load enable.
- IDEX_Flush  out  1  load bubble (all control 0) into ID/EX.
- EXMEM_Write  out  1  EX/MEM load enable.
- MEMWB_Bubble  out  1  load bubble into MEM/WB.
- MemReq  out  1  memory access request.
- StallCnt  out  CNT_W  saturating count of stalled cycles.
- MemErr  out  1  sticky timeout flag (tied 0 when the optional feature is absent).

Behaviour:
- Reset (Rst=0, asynchronous): state=RUN, StallCnt=0, MemErr=0, MemReq=0. All *_Write=1, all flushes and MEMWB_Bubble=0.
- access = MEM_MEM[1] | MEM_MEM[0]. MemReq = access, combinational.
- FSM states RUN and MEM_WAIT.
  - RUN: access & ~MemReady -> freeze this cycle, next state MEM_WAIT. Otherwise stay in RUN.
  - MEM_WAIT: ~MemReady -> freeze, stay. MemReady -> no freeze this cycle, next state RUN.
- Freeze: PCWrite = IFID_Write = IDEX_Write = EXMEM_Write = 0, MEMWB_Bubble = 1. While frozen, all flushes are forced 0.
- Load-use condition: MEM_EX[1] & (WN_EX != 0) & (WN_EX == Rs_ID | (UseRt_ID & WN_EX == Rt_ID)). Response: PCWrite = IFID_Write = 0, IDEX_Flush = 1 for exactly one cycle.
- Taken branch: IFID_Flush = IDEX_Flush = 1; PC load stays enabled.
- Priority: freeze > branch flush > load-use.
  - A branch coincident with load-use gives flush only; PCWrite=1.
  - A branch during freeze is held and re-evaluated when the freeze releases.
- StallCnt increments by 1 on each cycle with freeze or load-use stall. It saturates at all-ones and is never cleared except by reset.
- Single-cycle memory (MemReady=1 in the first MEM cycle) causes zero stall.
- Reset mid-MEM_WAIT: immediate return to RUN with reset output values.

Optional Feature:
- Macro: PIPE_STALL_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on entry to MEM_WAIT and increments every MEM_WAIT cycle. When it reaches TIMEOUT_CYC with MemReady still 0:
  - MemErr is set (sticky until reset);
  - FSM returns to RUN and the freeze releases that cycle;
  - MEMWB_Bubble stays 1 for that cycle, so the failed access never writes back.
- Undefined: no counter is built, MemErr is driven 0, and MEM_WAIT is held indefinitely.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - MEM bit-position constants (MEM_RD=1, MEM_WR=0);
  - default CNT_W and TIMEOUT_CYC.
- Sub-module pipe_loaduse_det: purely combinational load-use comparator, instantiated once.

Test Plan:
- Reset with Rst=0 mid-MEM_WAIT -> state RUN, all Write=1, StallCnt=0, MemErr=0, asynchronously before the next edge.
- MEM_EX=2'b10, WN_EX=5, Rs_ID=5 -> exactly 1 cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallCnt +1. Repeat with WN_EX=0 -> no stall.
- MEM_MEM=2'b10 with MemReady low for 3 cycles then high -> 3 frozen cycles, EXMEM_Write=0 and MEMWB_Bubble=1 throughout, release on the MemReady cycle, StallCnt=3.
- BranchTaken_EX=1 together with the load-use condition -> IFID_Flush=IDEX_Flush=1, PCWrite=1, StallCnt unchanged.
- BranchTaken_EX=1 during a memory freeze -> flushes 0 until MemReady, then flush asserted in the release cycle.
- With PIPE_STALL_TIMEOUT_EN, TIMEOUT_CYC=4, MemReady stuck 0 -> MemErr=1 after 4 MEM_WAIT cycles, freeze released, MEMWB_Bubble=1 that cycle, MemErr sticky.
